// File: rtl/basic_io_pkg.sv
// Shared types and helpers for the LogiPi basic I/O controller.
package basic_io_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_MIRROR = 2'd0,
    MODE_COUNT  = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_SHIFT  = 2'd3
  } mode_e;

  // Counter width able to hold 0..max_count-1, never narrower than one bit.
  function automatic int cnt_width(input int max_count);
    int w;
    w = $clog2(max_count);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/io_debounce.sv
// Single-bit 2-flop synchroniser followed by a stability-count debouncer.
module io_debounce
  import basic_io_pkg::*;
#(
  parameter int DEB_CYCLES = 50000
) (
  input  logic OSC_FPGA,
  input  logic RST_N,
  input  logic din,
  output logic dout
);

  localparam int              CNT_W    = cnt_width(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic             deb_r;
  logic [CNT_W-1:0] cnt_r;

  // Two-flop synchroniser for the asynchronous pin.
  always_ff @(posedge OSC_FPGA or negedge RST_N) begin
    if (!RST_N) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= din;
      sync2_r <= sync1_r;
    end
  end

  // Any return to the held value restarts the stability count.
  always_ff @(posedge OSC_FPGA or negedge RST_N) begin
    if (!RST_N) begin
      deb_r <= 1'b0;
      cnt_r <= '0;
    end else if (sync2_r == deb_r) begin
      cnt_r <= '0;
    end else if (cnt_r == CNT_LAST) begin
      deb_r <= sync2_r;
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign dout = deb_r;

endmodule

// File: rtl/basic_io_ctrl.sv
// Board I/O controller: debounced buttons/switches, press pulses and LED modes.
// Build option BASIC_IO_BLINK_EN adds the BLINK mode and its prescaler.
module basic_io_ctrl
  import basic_io_pkg::*;
#(
  parameter int N_IO       = 2,
  parameter int DEB_CYCLES = 50000,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic            OSC_FPGA,
  input  logic            RST_N,
  input  logic [N_IO-1:0] PB,
  input  logic [N_IO-1:0] SW,
  output logic [N_IO-1:0] LED,
  output logic [N_IO-1:0] PB_PRESS
);

  localparam logic [N_IO-1:0] SHIFT_INIT = {{(N_IO-1){1'b0}}, 1'b1};

  if (N_IO < 2 || DEB_CYCLES < 2 || BLINK_DIV < 2) begin : g_bad_param
    $error("basic_io_ctrl: N_IO, DEB_CYCLES and BLINK_DIV must all be >= 2");
  end

  logic [N_IO-1:0] pb_deb_s;
  logic [N_IO-1:0] sw_deb_s;
  logic [N_IO-1:0] pb_deb_prev_r;
  logic [N_IO-1:0] pb_rise_r;
  logic [N_IO-1:0] press_cnt_r;
  logic [N_IO-1:0] shift_reg_r;
  logic [N_IO-1:0] led_next_s;
  mode_e           mode_r;
  mode_e           mode_next_s;

  for (genvar i = 0; i < N_IO; i++) begin : g_deb
    io_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_pb_deb (
      .OSC_FPGA (OSC_FPGA),
      .RST_N    (RST_N),
      .din      (PB[i]),
      .dout     (pb_deb_s[i])
    );
    io_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_sw_deb (
      .OSC_FPGA (OSC_FPGA),
      .RST_N    (RST_N),
      .din      (SW[i]),
      .dout     (sw_deb_s[i])
    );
  end

  // Rising-edge detect on debounced buttons; PB_PRESS trails pb_rise by a cycle.
  always_ff @(posedge OSC_FPGA or negedge RST_N) begin
    if (!RST_N) begin
      pb_deb_prev_r <= '0;
      pb_rise_r     <= '0;
      PB_PRESS      <= '0;
    end else begin
      pb_deb_prev_r <= pb_deb_s;
      pb_rise_r     <= pb_deb_s & ~pb_deb_prev_r;
      PB_PRESS      <= pb_rise_r;
    end
  end

`ifdef BASIC_IO_BLINK_EN
  localparam int               PRE_W    = cnt_width(BLINK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(BLINK_DIV - 1);

  logic [PRE_W-1:0] prescale_r;
  logic             blink_phase_r;

  // Free-running prescaler; the phase flips once per full count.
  always_ff @(posedge OSC_FPGA or negedge RST_N) begin
    if (!RST_N) begin
      prescale_r    <= '0;
      blink_phase_r <= 1'b0;
    end else if (prescale_r == PRE_LAST) begin
      prescale_r    <= '0;
      blink_phase_r <= ~blink_phase_r;
    end else begin
      prescale_r    <= prescale_r + PRE_W'(1);
    end
  end
`endif

  // Mode sequencing on a bit-1 press; BLINK is skipped when it is not built.
  always_comb begin
    mode_next_s = mode_r;
    if (pb_rise_r[1]) begin
      case (mode_r)
        MODE_MIRROR: mode_next_s = MODE_COUNT;
`ifdef BASIC_IO_BLINK_EN
        MODE_COUNT:  mode_next_s = MODE_BLINK;
`else
        MODE_COUNT:  mode_next_s = MODE_SHIFT;
`endif
        MODE_BLINK:  mode_next_s = MODE_SHIFT;
        MODE_SHIFT:  mode_next_s = MODE_MIRROR;
        default:     mode_next_s = MODE_MIRROR;
      endcase
    end else begin
      mode_next_s = mode_r;
    end
  end

  // LED source selection from the registered mode and state.
  always_comb begin
    led_next_s = sw_deb_s;
    case (mode_r)
      MODE_MIRROR: led_next_s = sw_deb_s;
      MODE_COUNT:  led_next_s = press_cnt_r;
`ifdef BASIC_IO_BLINK_EN
      MODE_BLINK:  led_next_s = {N_IO{blink_phase_r}} & sw_deb_s;
`else
      MODE_BLINK:  led_next_s = sw_deb_s;
`endif
      MODE_SHIFT:  led_next_s = shift_reg_r;
      default:     led_next_s = sw_deb_s;
    endcase
  end

  // Mode, press counter, one-hot rotator and LED register.
  always_ff @(posedge OSC_FPGA or negedge RST_N) begin
    if (!RST_N) begin
      mode_r      <= MODE_MIRROR;
      press_cnt_r <= '0;
      shift_reg_r <= SHIFT_INIT;
      LED         <= '0;
    end else begin
      mode_r <= mode_next_s;
      LED    <= led_next_s;
      if (pb_rise_r[0]) begin
        press_cnt_r <= press_cnt_r + N_IO'(1);
        shift_reg_r <= {shift_reg_r[N_IO-2:0], shift_reg_r[N_IO-1]};
      end else begin
        press_cnt_r <= press_cnt_r;
        shift_reg_r <= shift_reg_r;
      end
    end
  end

endmodule

// File: tb/tb_basic_io_ctrl.sv
// Directed self-checking bench for basic_io_ctrl (N_IO=4, DEB_CYCLES=4, BLINK_DIV=8).
module tb_basic_io_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] pb;
  logic [3:0] sw;
  logic [3:0] led;
  logic [3:0] pb_press;

  int         test_cnt = 0;
  int         fail_cnt = 0;
  logic [3:0] press_seen;

  basic_io_ctrl #(
    .N_IO       (4),
    .DEB_CYCLES (4),
    .BLINK_DIV  (8)
  ) u_dut (
    .OSC_FPGA (clk),
    .RST_N    (rst_n),
    .PB       (pb),
    .SW       (sw),
    .LED      (led),
    .PB_PRESS (pb_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    test_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pb    = 4'b0000;
    sw    = 4'b0000;
    wait_neg(3);
    rst_n = 1'b1;
    wait_neg(2);
  endtask

  // Hold a button mask long enough to register, capturing PB_PRESS at its expected cycle.
  task automatic press(input logic [3:0] mask);
    pb = mask;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 8) press_seen = pb_press;
    end
    pb = 4'b0000;
    wait_neg(10);
  endtask

  initial begin
    int         pulses;
    int         pulse_at;
    int         bad;
    bit         found;
    logic [3:0] prev;
    logic [3:0] v0;
    logic [3:0] v1;

    rst_n = 1'b0;
    pb    = 4'($urandom);
    sw    = 4'($urandom);
    press_seen = 4'b0000;

    // Reset with random inputs, then release with quiet inputs
    wait_neg(5);
    check_val("rst_led", led, 4'b0000);
    check_val("rst_press", pb_press, 4'b0000);
    pb = 4'b0000;
    sw = 4'b0000;
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (led !== 4'b0000 || pb_press !== 4'b0000) bad++;
    end
    check_val("rel_quiet", bad, 0);

    // Bounce on PB[0]: only the final steady level produces a pulse
    pulses = 0;
    pulse_at = 0;
    for (int k = 0; k < 10; k++) begin
      pb[0] = ~pb[0];
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        if (pb_press[0]) pulses++;
      end
    end
    pb[0] = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (pb_press[0]) begin
        pulses++;
        pulse_at = c;
      end
    end
    check_val("bounce_pulses", pulses, 1);
    check_val("bounce_latency", pulse_at, 8);
    pb = 4'b0000;
    wait_neg(10);

    // MIRROR latency and glitch rejection
    do_reset();
    sw = 4'b1010;
    wait_neg(6);
    check_val("mirror_pre", led, 4'b0000);
    wait_neg(1);
    check_val("mirror_led", led, 4'b1010);
    sw = 4'b0000;
    wait_neg(3);
    sw = 4'b1010;
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (led !== 4'b1010) bad++;
    end
    check_val("glitch_hold", bad, 0);

    // COUNT mode and wrap
    do_reset();
    press(4'b0010);
    check_val("mode_press_pulse", press_seen, 4'b0010);
    check_val("count_start", led, 4'b0000);
    for (int k = 0; k < 15; k++) press(4'b0001);
    check_val("count_15", led, 4'b1111);
    press(4'b0001);
    check_val("count_wrap", led, 4'b0000);
    pb = 4'b0001;
    wait_neg(8);
    check_val("count_lat_pre", led, 4'b0000);
    wait_neg(1);
    check_val("count_lat", led, 4'b0001);
    pb = 4'b0000;
    wait_neg(12);

    // SHIFT: 17 rotations from 0001 leaves 0010
`ifdef BASIC_IO_BLINK_EN
    press(4'b0010);
`endif
    press(4'b0010);
    check_val("shift_led", led, 4'b0010);
    press(4'b0001);
    check_val("shift_rot", led, 4'b0100);
    sw = 4'b1100;
    press(4'b0010);
    check_val("shift_to_mirror", led, 4'b1100);

`ifdef BASIC_IO_BLINK_EN
    // BLINK: LED alternates between 0000 and SW every 8 clocks
    do_reset();
    sw = 4'b0110;
    wait_neg(10);
    press(4'b0010);
    press(4'b0010);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      prev = led;
      @(negedge clk);
      if (led !== prev) found = 1'b1;
    end
    check_val("blink_toggle_seen", found, 1'b1);
    v0 = led;
    v1 = (v0 == 4'b0000) ? 4'b0110 : 4'b0000;
    check_val("blink_level", (v0 == 4'b0000) || (v0 == 4'b0110), 1'b1);
    bad = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (led !== v0) bad++;
    end
    check_val("blink_hold0", bad, 0);
    @(negedge clk);
    check_val("blink_flip1", led, v1);
    bad = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (led !== v1) bad++;
    end
    check_val("blink_hold1", bad, 0);
    @(negedge clk);
    check_val("blink_flip2", led, v0);
`endif

    // Simultaneous presses from MIRROR with press_cnt=0011
    do_reset();
    for (int k = 0; k < 3; k++) press(4'b0001);
    check_val("simul_pre_led", led, 4'b0000);
    press(4'b0011);
    check_val("simul_pulse", press_seen, 4'b0011);
    check_val("simul_led", led, 4'b0100);

    // Reset while a press is in flight
    pb = 4'b0010;
    wait_neg(7);
    rst_n = 1'b0;
    #1;
    check_val("midrst_led", led, 4'b0000);
    check_val("midrst_press", pb_press, 4'b0000);
    pb = 4'b0000;
    wait_neg(3);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (pb_press !== 4'b0000) bad++;
    end
    check_val("midrst_no_pulse", bad, 0);
    sw = 4'b0101;
    wait_neg(8);
    check_val("midrst_mirror", led, 4'b0101);
    press(4'b0010);
    check_val("midrst_cnt", led, 4'b0000);
`ifdef BASIC_IO_BLINK_EN
    press(4'b0010);
`endif
    press(4'b0010);
    check_val("midrst_shift", led, 4'b0001);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/basic_io_ctrl.md
# basic_io_ctrl

- Parametrised board I/O controller for the LogiPi basic I/O design; replaces the direct switch-to-LED mirror.
- Debounces and synchronises N_IO push-buttons and switches, and emits one-cycle press pulses.
- Drives the LEDs from a mode state machine: switch mirror, press counter, blink, or rotating one-hot.
- Sits directly between the board pins and the rest of the FPGA logic, clocked by the board oscillator.

## Interface
Parameters:
- N_IO, 2: width of PB, SW, LED and PB_PRESS; must be >= 2.
- DEB_CYCLES, 50000: consecutive stable clocks required before a debounced input changes; must be >= 2.
- BLINK_DIV, 25000000: blink half-period in clocks; must be >= 2.

Ports:
- OSC_FPGA, in, 1: board oscillator; the single clock.
- RST_N, in, 1: asynchronous, active-low reset.
- PB, in, N_IO: raw push-buttons, active-high, asynchronous to OSC_FPGA.
- SW, in, N_IO: raw slide switches, asynchronous to OSC_FPGA.
- LED, out, N_IO: registered LED drive.
- PB_PRESS, out, N_IO: one-cycle pulse per debounced rising edge of each PB bit.

## Operation
- Every PB and SW bit passes through a 2-flop synchroniser, then its own debouncer.
- Debouncer state: debounced value plus a stability counter, ceil(log2(DEB_CYCLES)) bits wide.
  - Synced value equals the debounced value: counter clears.
  - Otherwise the counter increments; at DEB_CYCLES-1 the debounced value takes the synced value and the counter clears.
  - A glitch shorter than DEB_CYCLES clocks never changes the debounced value.
- pb_rise[i] = debounced PB[i] high and its previous-cycle value low. PB_PRESS is pb_rise registered.
- Mode register, 2-bit encoding: MIRROR=0, COUNT=1, BLINK=2, SHIFT=3.
  - A PB press on bit 1 advances the mode MIRROR->COUNT->BLINK->SHIFT->MIRROR.
- A PB press on bit 0 does two things:
  - Increments press_cnt (N_IO bits, wraps all-ones to 0).
  - Rotates one-hot shift_reg left by one; the MSB wraps to the LSB.
- press_cnt and shift_reg update in every mode.
- Blink prescaler: free-running 0..BLINK_DIV-1 in all modes; blink_phase toggles at the terminal count.
- LED next value by mode:
  - MIRROR: debounced SW.
  - COUNT: press_cnt.
  - BLINK: {N_IO{blink_phase}} & debounced SW.
  - SHIFT: shift_reg.
- Simultaneous presses on bit 0 and bit 1 in the same cycle: both updates happen. LED then shows the new mode with the updated counter/shift value.
- PB bits 2..N_IO-1 only produce PB_PRESS pulses.
- Reset values: LED=0, PB_PRESS=0, mode=MIRROR, press_cnt=0, shift_reg=1, blink_phase=0, prescaler=0, all debounced values=0, all synchroniser flops=0.
- Reset asserted mid-operation returns everything to these values immediately. Pulses in flight are dropped.

## Timing
- Raw input change, held stable, to debounced change: 2 + DEB_CYCLES clocks.
- Debounced PB rise to PB_PRESS high: 2 clocks. PB_PRESS lasts exactly 1 clock per press.
- pb_rise to mode/press_cnt/shift_reg updated: 1 clock. LED reflects the update 1 clock later.
- Debounced SW change to LED in MIRROR: 1 clock.
- Blink: LED toggles every BLINK_DIV clocks; first toggle BLINK_DIV clocks after reset release.
- After reset release no PB_PRESS can fire for at least 2 + DEB_CYCLES clocks.

## Configuration
- BASIC_IO_BLINK_EN defined: behaviour as above.
- BASIC_IO_BLINK_EN undefined:
  - Prescaler and blink_phase are not built.
  - Mode sequence is MIRROR->COUNT->SHIFT->MIRROR; code 2 is never entered.
  - If the mode register ever holds 2, LED shows MIRROR.
- Encoding and all other timing are unchanged in both builds.

## Structure
- basic_io_pkg holds:
  - The mode enum and its 2-bit encoding.
  - MODE_W = 2.
  - A clog2-based width function for the debounce counter and prescaler.
- One sub-module, io_debounce: 2-flop synchroniser plus debouncer for a single bit, parameter DEB_CYCLES, ports OSC_FPGA/RST_N/din/dout.
  - basic_io_ctrl instantiates it 2*N_IO times.

## Test plan
Run with N_IO=4, DEB_CYCLES=4, BLINK_DIV=8.
- Reset: hold RST_N=0 with random PB/SW -> LED=0000, PB_PRESS=0000; release with inputs 0 -> outputs stay 0.
- Bounce: PB[0] toggled every 2 clocks for 20 clocks, then held high -> exactly one PB_PRESS[0] pulse, 2+4+2 clocks after the final edge.
- MIRROR: SW=1010 stable -> LED=1010 at 2+4+1 clocks; a 3-clock SW glitch to 0000 -> LED unchanged.
- COUNT wrap: 1 press on PB[1], then 17 presses on PB[0] -> LED shows 0001 after wrapping through 1111->0000. SHIFT: press PB[1] twice (with blink built) -> LED=0010.
- BLINK: SW=0110, mode BLINK -> LED alternates 0000/0110 every 8 clocks. Without BASIC_IO_BLINK_EN, one PB[1] press from COUNT goes to SHIFT.
- Simultaneous: PB[0] and PB[1] debounced rising in the same cycle from MIRROR with press_cnt=0011 -> next mode COUNT, LED=0100; RST_N pulsed mid-press -> all state back to reset values.
